data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_pkg.sv | 37 +++
 rtl/data_memory_mem_array.sv | 29 ++
 rtl/data_memory.sv | 168 ++++++++++++++++
 tb/tb_data_memory.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared encodings for data_memory: RISC-V load/store size codes, FSM states,
// MMIO register offsets and the load lane-extraction helper.
package data_memory_pkg;

   localparam logic [2:0] RAM_SIZE_B  = 3'b000;
   localparam logic [2:0] RAM_SIZE_H  = 3'b001;
   localparam logic [2:0] RAM_SIZE_W  = 3'b010;
   localparam logic [2:0] RAM_SIZE_BU = 3'b100;
   localparam logic [2:0] RAM_SIZE_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESPOND
   } state_e;

   localparam logic [31:0] MMIO_CNT_OFF = 32'd0;
   localparam logic [31:0] MMIO_OUT_OFF = 32'd4;

   // Pick the addressed lane(s) out of a word and extend to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  size);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         RAM_SIZE_B:  load_extract = {{24{b[7]}}, b};
         RAM_SIZE_BU: load_extract = {24'd0, b};
         RAM_SIZE_H:  load_extract = {{16{h[15]}}, h};
         RAM_SIZE_HU: load_extract = {16'd0, h};
         default:     load_extract = word;
      endcase
   endfunction

endpackage

// File: rtl/data_memory_mem_array.sv
// Single-port DEPTH_WORDS x 32 storage with per-byte write enables and a
// registered read port; contents are never reset.
module mem_array #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned AW          = 10
) (
   input  logic          clk_i,
   input  logic [AW-1:0] addr_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Byte-addressable data memory with a 3-state request/response handshake.
// Optional MMIO (cycle counter + output register) enabled by DATA_MEMORY_MMIO_EN.
module data_memory
   import data_memory_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ram_req,
   input  logic [31:0] ram_adress,
   input  logic [31:0] data_out_ram,
   input  logic        ram_enable_write,
   input  logic [2:0]  ram_size,
   output logic [31:0] data_in_ram,
   output logic        ram_ready,
   output logic        ram_error,
   output logic [31:0] mmio_out
);

   localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;

   state_e      state_q, state_d;
   logic [31:0] addr_q, wdata_q;
   logic [2:0]  size_q;
   logic        we_q;
   logic        ram_ready_q, ram_error_q;
   logic [31:0] data_in_ram_q;

   logic        size_bad, misaligned, in_ram, cnt_hit, out_hit, mmio_sel;
   logic        range_fault, mmio_fault, fault;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (ram_req) state_d = ST_ACCESS;
         ST_ACCESS:  state_d = ST_RESPOND;
         ST_RESPOND: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Transaction capture: the core may change its inputs right after the request edge.
   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && ram_req) begin
         addr_q  <= ram_adress;
         wdata_q <= data_out_ram;
         size_q  <= ram_size;
         we_q    <= ram_enable_write;
      end
   end

   always_comb begin
      size_bad   = 1'b0;
      misaligned = 1'b0;
      case (size_q)
         RAM_SIZE_B, RAM_SIZE_BU: misaligned = 1'b0;
         RAM_SIZE_H, RAM_SIZE_HU: misaligned = addr_q[0];
         RAM_SIZE_W:              misaligned = |addr_q[1:0];
         default:                 size_bad   = 1'b1;
      endcase
   end

   assign in_ram   = ({1'b0, addr_q} < MEM_BYTES);
   assign cnt_hit  = (addr_q == MMIO_BASE + MMIO_CNT_OFF);
   assign out_hit  = (addr_q == MMIO_BASE + MMIO_OUT_OFF);
   assign mmio_sel = cnt_hit | out_hit;

`ifdef DATA_MEMORY_MMIO_EN
   assign range_fault = !in_ram && !mmio_sel;
   assign mmio_fault  = mmio_sel && ((size_q != RAM_SIZE_W) || (we_q && cnt_hit));
`else
   assign range_fault = !in_ram || mmio_sel;
   assign mmio_fault  = 1'b0;
`endif

   assign fault = size_bad | misaligned | range_fault | mmio_fault;

   always_comb begin
      mem_be    = 4'b0000;
      mem_wdata = wdata_q;
      case (size_q)
         RAM_SIZE_B: begin
            mem_be    = 4'b0001 << addr_q[1:0];
            mem_wdata = {4{wdata_q[7:0]}};
         end
         RAM_SIZE_H: begin
            mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{wdata_q[15:0]}};
         end
         RAM_SIZE_W: mem_be = 4'b1111;
         default:    mem_be = 4'b0000;
      endcase
   end

   // Read is launched from the live address in IDLE so the word is ready during ACCESS.
   assign mem_addr = (state_q == ST_ACCESS) ? addr_q[AW+1:2] : ram_adress[AW+1:2];
   assign mem_we   = (state_q == ST_ACCESS) && we_q && !fault && !mmio_sel && !rst;

   mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_mem_array (
      .clk_i   (clk),
      .addr_i  (mem_addr),
      .we_i    (mem_we),
      .be_i    (mem_be),
      .wdata_i (mem_wdata),
      .rdata_o (mem_rdata)
   );

`ifdef DATA_MEMORY_MMIO_EN
   logic [31:0] cnt_q;
   logic [31:0] mmio_out_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= 32'd0;
         mmio_out_q <= 32'd0;
      end else begin
         cnt_q <= cnt_q + 32'd1;
         if (state_q == ST_ACCESS && we_q && !fault && out_hit) mmio_out_q <= wdata_q;
      end
   end

   assign mmio_out = mmio_out_q;
`else
   assign mmio_out = 32'd0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         ram_ready_q   <= 1'b0;
         ram_error_q   <= 1'b0;
         data_in_ram_q <= 32'd0;
      end else begin
         ram_ready_q <= (state_q == ST_ACCESS);
         if (state_q == ST_ACCESS) begin
            ram_error_q <= fault;
            if (fault || we_q) begin
               data_in_ram_q <= 32'd0;
`ifdef DATA_MEMORY_MMIO_EN
            end else if (mmio_sel) begin
               data_in_ram_q <= cnt_hit ? cnt_q : mmio_out_q;
`endif
            end else begin
               data_in_ram_q <= load_extract(mem_rdata, addr_q[1:0], size_q);
            end
         end
      end
   end

   assign ram_ready   = ram_ready_q;
   assign ram_error   = ram_error_q;
   assign data_in_ram = data_in_ram_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory; MMIO checks follow DATA_MEMORY_MMIO_EN.
module tb_data_memory;

   localparam logic [31:0] MMIO_BASE = 32'hFFFF0000;
   localparam logic [2:0]  SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010,
                           SZ_BU = 3'b100, SZ_HU = 3'b101;

   logic        clk, rst, ram_req, ram_enable_write;
   logic [31:0] ram_adress, data_out_ram, data_in_ram, mmio_out;
   logic [2:0]  ram_size;
   logic        ram_ready, ram_error;

   int n_checks = 0;
   int n_errors = 0;

   data_memory #(
      .DEPTH_WORDS (1024),
      .MMIO_BASE   (MMIO_BASE)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .ram_req          (ram_req),
      .ram_adress       (ram_adress),
      .data_out_ram     (data_out_ram),
      .ram_enable_write (ram_enable_write),
      .ram_size         (ram_size),
      .data_in_ram      (data_in_ram),
      .ram_ready        (ram_ready),
      .ram_error        (ram_error),
      .mmio_out         (mmio_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One full transaction; lat counts negedges from the request edge until ready is seen.
   task automatic do_access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output logic err,
                            output int lat, output logic rdy_tail);
      @(negedge clk);
      ram_req = 1'b1; ram_adress = addr; data_out_ram = wd;
      ram_enable_write = we; ram_size = sz;
      @(posedge clk); #1;
      ram_req = 1'b0; ram_adress = 32'h4; data_out_ram = ~wd;
      ram_enable_write = ~we; ram_size = SZ_W;
      lat = 0; rd = 32'hx; err = 1'bx;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         lat++;
         if (ram_ready) begin
            rd = data_in_ram; err = ram_error;
            break;
         end
      end
      @(posedge clk); #1;
      rdy_tail = ram_ready;
   endtask

   logic [31:0] rd, rd2;
   logic        err, tail;
   int          lat, pulses;

   initial begin
      rst = 1'b1; ram_req = 1'b0; ram_adress = 32'h0; data_out_ram = 32'h0;
      ram_enable_write = 1'b0; ram_size = SZ_W;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ready", 32'(ram_ready), 32'd0);
      check_eq("rst_error", 32'(ram_error), 32'd0);
      check_eq("rst_data",  data_in_ram, 32'd0);
      check_eq("rst_mmio",  mmio_out, 32'd0);
      @(negedge clk); rst = 1'b0;

      do_access(1'b1, SZ_W, 32'h10, 32'hDEADBEEF, rd, err, lat, tail);
      check_eq("sw_lat", 32'(lat), 32'd2);
      check_eq("sw_err", 32'(err), 32'd0);
      check_eq("sw_data", rd, 32'd0);
      check_eq("sw_pulse_end", 32'(tail), 32'd0);
      do_access(1'b0, SZ_W, 32'h10, 32'h0, rd, err, lat, tail);
      check_eq("lw_lat", 32'(lat), 32'd2);
      check_eq("lw_err", 32'(err), 32'd0);
      check_eq("lw_data", rd, 32'hDEADBEEF);
      repeat (3) @(posedge clk);
      #1 check_eq("data_hold", data_in_ram, 32'hDEADBEEF);

      do_access(1'b1, SZ_B, 32'h13, 32'h12345680, rd, err, lat, tail);
      check_eq("sb_err", 32'(err), 32'd0);
      do_access(1'b0, SZ_B, 32'h13, 32'h0, rd, err, lat, tail);
      check_eq("lb", rd, 32'hFFFFFF80);
      do_access(1'b0, SZ_BU, 32'h13, 32'h0, rd, err, lat, tail);
      check_eq("lbu", rd, 32'h00000080);
      do_access(1'b0, SZ_W, 32'h10, 32'h0, rd, err, lat, tail);
      check_eq("lw_after_sb", rd, 32'h80ADBEEF);
      do_access(1'b0, SZ_H, 32'h12, 32'h0, rd, err, lat, tail);
      check_eq("lh", rd, 32'hFFFF80AD);
      do_access(1'b0, SZ_HU, 32'h10, 32'h0, rd, err, lat, tail);
      check_eq("lhu", rd, 32'h0000BEEF);
      do_access(1'b1, SZ_H, 32'h16, 32'hAAAA1234, rd, err, lat, tail);
      do_access(1'b0, SZ_W, 32'h14, 32'h0, rd, err, lat, tail);
      check_eq("sh_upper_lanes", rd[31:16], 32'h1234);

      do_access(1'b0, SZ_W, 32'h12, 32'h0, rd, err, lat, tail);
      check_eq("lw_mis_err", 32'(err), 32'd1);
      check_eq("lw_mis_data", rd, 32'd0);
      do_access(1'b1, SZ_H, 32'h11, 32'hFFFF, rd, err, lat, tail);
      check_eq("sh_mis_err", 32'(err), 32'd1);
      do_access(1'b0, SZ_W, 32'h10, 32'h0, rd, err, lat, tail);
      check_eq("lw_unchanged", rd, 32'h80ADBEEF);
      check_eq("lw_unchanged_err", 32'(err), 32'd0);
      do_access(1'b0, SZ_W, 32'd4096, 32'h0, rd, err, lat, tail);
      check_eq("oob_err", 32'(err), 32'd1);
      check_eq("oob_data", rd, 32'd0);
      do_access(1'b0, 3'b011, 32'h10, 32'h0, rd, err, lat, tail);
      check_eq("badsize_err", 32'(err), 32'd1);

      // Request held high for six edges: accepted on edges 0 and 3 only.
      @(negedge clk);
      ram_req = 1'b1; ram_adress = 32'h10; ram_enable_write = 1'b0; ram_size = SZ_W;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (i == 5) ram_req = 1'b0;
         if (ram_ready) pulses++;
      end
      check_eq("held_req_pulses", 32'(pulses), 32'd2);

      do_access(1'b1, SZ_W, 32'h20, 32'h11111111, rd, err, lat, tail);
      @(negedge clk);
      ram_req = 1'b1; ram_adress = 32'h20; data_out_ram = 32'h22222222;
      ram_enable_write = 1'b1; ram_size = SZ_W;
      @(posedge clk); #1;
      ram_req = 1'b0; rst = 1'b1;
      pulses = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      if (ram_ready) pulses++;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (ram_ready) pulses++;
      end
      check_eq("rst_abort_pulses", 32'(pulses), 32'd0);
      do_access(1'b0, SZ_W, 32'h20, 32'h0, rd, err, lat, tail);
      check_eq("rst_abort_nowrite", rd, 32'h11111111);

`ifdef DATA_MEMORY_MMIO_EN
      do_access(1'b1, SZ_W, MMIO_BASE + 32'd4, 32'h5, rd, err, lat, tail);
      check_eq("mmio_sw_err", 32'(err), 32'd0);
      check_eq("mmio_out", mmio_out, 32'h5);
      do_access(1'b0, SZ_W, MMIO_BASE + 32'd4, 32'h0, rd, err, lat, tail);
      check_eq("mmio_out_rd", rd, 32'h5);
      do_access(1'b0, SZ_W, MMIO_BASE, 32'h0, rd, err, lat, tail);
      repeat (7) @(posedge clk);
      do_access(1'b0, SZ_W, MMIO_BASE, 32'h0, rd2, err, lat, tail);
      check_eq("cnt_delta", rd2 - rd, 32'd10);
      do_access(1'b1, SZ_W, MMIO_BASE, 32'h7, rd, err, lat, tail);
      check_eq("cnt_store_err", 32'(err), 32'd1);
      do_access(1'b0, SZ_B, MMIO_BASE + 32'd4, 32'h0, rd, err, lat, tail);
      check_eq("mmio_byte_err", 32'(err), 32'd1);
`else
      do_access(1'b0, SZ_W, MMIO_BASE, 32'h0, rd, err, lat, tail);
      check_eq("nommio_lw_err", 32'(err), 32'd1);
      do_access(1'b1, SZ_W, MMIO_BASE + 32'd4, 32'h5, rd, err, lat, tail);
      check_eq("nommio_sw_err", 32'(err), 32'd1);
      check_eq("nommio_out", mmio_out, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
